conv_out_packer: RTL
====================

CONV_OUT_PACKER -- requirements
Module: conv_out_packer

Interface
REQ-001 The block SHALL have parameter IMG_HEIGHT, default 2, meaning output image height in pixels.
REQ-002 The block SHALL have parameter IMG_WIDTH, default 2, meaning output image width in pixels.
REQ-003 The block SHALL have parameter WORD_WIDTH, default 8, meaning bits per filter result.
REQ-004 The block SHALL have parameter FILTERS, default 8, meaning results per output pixel.
REQ-005 The block SHALL have parameter FILTER_PER_LINE, default 2, meaning results per input transfer; FILTERS is an integer multiple of it.
REQ-006 The block SHALL derive localparams as follows:
- CHUNKS = FILTERS/FILTER_PER_LINE
- IN_BITS = WORD_WIDTH*FILTER_PER_LINE
- OUT_BITS = WORD_WIDTH*FILTERS
- PIXELS = IMG_HEIGHT*IMG_WIDTH
REQ-007 i_aclk  in  1  sole clock; all state on rising edge.
REQ-008 i_aresetn  in  1  reset, asynchronous assert, active-low.
REQ-009 i_tvalid  in  1  input stream valid (chunk from convolution engine).
REQ-010 o_tready  out  1  input stream ready.
REQ-011 i_tdata  in  IN_BITS  chunk; word j = result of filter (chunk_idx*FILTER_PER_LINE + j).
REQ-012 o_tvalid  out  1  output pixel valid.
REQ-013 i_tready  in  1  downstream ready.
REQ-014 o_tdata  out  OUT_BITS  full pixel; word f (bits f*WORD_WIDTH upward) = filter f.
REQ-015 o_tuser  out  1  start of frame: first pixel of an image.
REQ-016 o_tlast  out  1  end of frame: pixel PIXELS-1 of an image.

Function
REQ-017 Input handshake SHALL occur on any edge with i_tvalid && o_tready.
REQ-018 Chunk counter 0..CHUNKS-1 SHALL select the target words of the assembly register and SHALL wrap to 0 after the handshake at CHUNKS-1.
REQ-019 The handshake at chunk CHUNKS-1 SHALL set asm_full; o_tready SHALL equal !asm_full, registered with no combinational path from i_tready.
REQ-020 When asm_full && (!o_tvalid || i_tready), the assembly register SHALL move to the hold register on the next edge, asm_full SHALL clear and o_tvalid SHALL be 1.
REQ-021 Latency SHALL be as follows:
- last-chunk handshake at edge T leads to o_tvalid high after edge T+1 when hold is free.
- sustained rate is one pixel per CHUNKS+1 cycles.
REQ-022 Output handshake SHALL occur on i_tready && o_tvalid; with no new pixel pending, o_tvalid SHALL drop after that edge.
REQ-023 While o_tvalid && !i_tready, o_tdata, o_tuser and o_tlast SHALL stay stable.
REQ-024 Pixel counter 0..PIXELS-1 SHALL advance on each assembly-to-hold move and wrap to 0 after PIXELS-1.
REQ-025 o_tuser SHALL be 1 for pixel index 0 and o_tlast SHALL be 1 for index PIXELS-1; both are registered with the data.
REQ-026 If PIXELS==1, o_tuser and o_tlast SHALL both be 1 on every pixel.
REQ-027 If asm_full and the hold register drains on the same edge, the move SHALL happen on that edge with no bubble cycle on o_tvalid.
REQ-028 i_tdata SHALL be ignored when no input handshake occurs.

Reset
REQ-029 On reset, outputs and state SHALL be as follows:
- o_tvalid=0, o_tdata=0, o_tuser=0, o_tlast=0
- chunk and pixel counters = 0, asm_full=0
REQ-030 o_tready SHALL be 0 while i_aresetn=0 and SHALL be 1 on the first cycle after release.
REQ-031 Reset mid-pixel or mid-frame SHALL discard partial chunks and pending pixels; the next pixel SHALL carry o_tuser=1.

Structure
REQ-032 Shared package conv2d_pkg SHALL hold:
- the CHUNKS, IN_BITS and OUT_BITS derivation functions
- a width helper clog2-plus-one for counters, shared with the convolution engine
REQ-033 Sub-module stream_hold_reg (data+user+last register with valid/ready, stable-under-stall) SHALL implement REQ-020 to REQ-023; the counters and assembly logic stay in conv_out_packer.

Verification
REQ-034 Pixel assembly: with defaults after reset, chunks 0x0201, 0x0403, 0x0605, 0x0807 and i_tready=1 SHALL give o_tdata=0x0807060504030201 and o_tuser=1, o_tlast=0, one cycle after the 4th handshake.
REQ-035 Stall: i_tready=0 for 12 cycles while a second pixel's 4 chunks arrive SHALL give the following:
- o_tdata holds the first pixel
- o_tready=0 after the 8th chunk
- on i_tready=1 the second pixel appears the next cycle and o_tready returns to 1.
REQ-036 Frame: over 5 pixels, o_tuser=1 on pixels 1 and 5 and o_tlast=1 on pixel 4 only.
REQ-037 Reset mid-pixel: 2 chunks, then i_aresetn=0 for 3 cycles, then chunks 0x11..0x88 SHALL give one pixel 0x8877665544332211 with o_tuser=1 and no other output.
REQ-038 Throughput: continuous i_tvalid=1 and i_tready=1 for 4 pixels SHALL finish the last output handshake within 22 cycles of the first input handshake, with o_tvalid never gapped while a full assembly waits.

Source files
------------

// File: rtl/conv2d_pkg.sv
// rtl/conv2d_pkg.sv - shared width derivations for the convolution datapath
package conv2d_pkg;

    function automatic int chunks_f(input int filters, input int filter_per_line);
        return filters / filter_per_line;
    endfunction

    function automatic int in_bits_f(input int word_width, input int filter_per_line);
        return word_width * filter_per_line;
    endfunction

    function automatic int out_bits_f(input int word_width, input int filters);
        return word_width * filters;
    endfunction

    // One spare bit so a counter can hold its own terminal count.
    function automatic int cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/stream_hold_reg.sv
// rtl/stream_hold_reg.sv - single-entry data/user/last register with valid/ready
module stream_hold_reg #(
    parameter int DATA_W = 64
) (
    input  logic              i_aclk,
    input  logic              i_aresetn,
    input  logic              s_tvalid,
    output logic              s_tready,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic              s_tuser,
    input  logic              s_tlast,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tuser,
    output logic              m_tlast
);

    // Loading while the current word drains keeps back-to-back output with no bubble.
    assign s_tready = !m_tvalid || m_tready;

    always_ff @(posedge i_aclk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
            m_tuser  <= 1'b0;
            m_tlast  <= 1'b0;
        end else if (s_tvalid && s_tready) begin
            m_tvalid <= 1'b1;
            m_tdata  <= s_tdata;
            m_tuser  <= s_tuser;
            m_tlast  <= s_tlast;
        end else if (m_tready) begin
            m_tvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/conv_out_packer.sv
// rtl/conv_out_packer.sv - gathers filter-result chunks into full output pixels
module conv_out_packer
    import conv2d_pkg::*;
#(
    parameter int IMG_HEIGHT      = 2,
    parameter int IMG_WIDTH       = 2,
    parameter int WORD_WIDTH      = 8,
    parameter int FILTERS         = 8,
    parameter int FILTER_PER_LINE = 2,
    localparam int CHUNKS   = chunks_f(FILTERS, FILTER_PER_LINE),
    localparam int IN_BITS  = in_bits_f(WORD_WIDTH, FILTER_PER_LINE),
    localparam int OUT_BITS = out_bits_f(WORD_WIDTH, FILTERS),
    localparam int PIXELS   = IMG_HEIGHT * IMG_WIDTH
) (
    input  logic                i_aclk,
    input  logic                i_aresetn,
    input  logic                i_tvalid,
    output logic                o_tready,
    input  logic [IN_BITS-1:0]  i_tdata,
    output logic                o_tvalid,
    input  logic                i_tready,
    output logic [OUT_BITS-1:0] o_tdata,
    output logic                o_tuser,
    output logic                o_tlast
);

    localparam int CW = cnt_width(CHUNKS);
    localparam int PW = cnt_width(PIXELS);

    logic [CW-1:0]       chunk_cnt;
    logic [PW-1:0]       pix_cnt;
    logic                asm_full;
    logic [OUT_BITS-1:0] asm_data;
    logic                hold_ready;
    logic                in_hs;
    logic                move;

    // Ready depends only on state and reset, never on downstream ready.
    assign o_tready = i_aresetn && !asm_full;
    assign in_hs    = i_tvalid && o_tready;
    assign move     = asm_full && hold_ready;

    always_ff @(posedge i_aclk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            chunk_cnt <= '0;
            pix_cnt   <= '0;
            asm_full  <= 1'b0;
            asm_data  <= '0;
        end else begin
            if (in_hs) begin
                for (int c = 0; c < CHUNKS; c++) begin
                    if (chunk_cnt == CW'(c)) begin
                        asm_data[c*IN_BITS +: IN_BITS] <= i_tdata;
                    end
                end
                if (chunk_cnt == CW'(CHUNKS - 1)) begin
                    chunk_cnt <= '0;
                    asm_full  <= 1'b1;
                end else begin
                    chunk_cnt <= chunk_cnt + 1'b1;
                end
            end
            if (move) begin
                asm_full <= 1'b0;
                pix_cnt  <= (pix_cnt == PW'(PIXELS - 1)) ? '0 : pix_cnt + 1'b1;
            end
        end
    end

    stream_hold_reg #(
        .DATA_W(OUT_BITS)
    ) u_hold (
        .i_aclk   (i_aclk),
        .i_aresetn(i_aresetn),
        .s_tvalid (asm_full),
        .s_tready (hold_ready),
        .s_tdata  (asm_data),
        .s_tuser  (pix_cnt == '0),
        .s_tlast  (pix_cnt == PW'(PIXELS - 1)),
        .m_tvalid (o_tvalid),
        .m_tready (i_tready),
        .m_tdata  (o_tdata),
        .m_tuser  (o_tuser),
        .m_tlast  (o_tlast)
    );

endmodule
